// File: rtl/mole_game_ctrl_pkg.sv
// Shared encodings for the whack-a-mole game controller: FSM states, sound modes
// and the special button codes.
package mole_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COUNT    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_PAUSE    = 3'd3,
        ST_STG_CLR  = 3'd4,
        ST_OVER     = 3'd5,
        ST_GAME_CLR = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        SND_NONE     = 3'd0,
        SND_BEEP     = 3'd1,
        SND_GO       = 3'd2,
        SND_HIT      = 3'd3,
        SND_MISS     = 3'd4,
        SND_STG_CLR  = 3'd5,
        SND_OVER     = 3'd6,
        SND_GAME_CLR = 3'd7
    } snd_e;

    // End-of-stage/game sound handshake phases
    typedef enum logic [1:0] {
        END_WAIT_IDLE = 2'd0,
        END_WAIT_BUSY = 2'd1,
        END_WAIT_DONE = 2'd2
    } end_ph_e;

    localparam logic [3:0] BTN_START = 4'd10;
    localparam logic [3:0] BTN_PAUSE = 4'd11;

    // Counter width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mole_game_ctrl_if.sv
// Game controller bus: timebase/button/mole/sound inputs and the game status outputs.
interface mole_game_ctrl_if #(
    parameter int N_HOLES = 8,
    parameter int STAGE_W = 2,
    parameter int LIVES_W = 2,
    parameter int SCORE_W = 10
);
    import mole_pkg::*;

    logic                sec_tick;
    logic                btn_press;
    logic [3:0]          btn_code;
    logic [N_HOLES-1:0]  mole_mask;
    logic                snd_busy;

    logic                snd_trig;
    logic [2:0]          snd_mode;
    logic                mole_en;
    logic [N_HOLES-1:0]  mole_hit;
    state_e              state;
    logic [STAGE_W-1:0]  stage;
    logic [LIVES_W-1:0]  lives;
    logic [SCORE_W-1:0]  score;
    logic [6:0]          timer;

    modport slave (
        input  sec_tick, btn_press, btn_code, mole_mask, snd_busy,
        output snd_trig, snd_mode, mole_en, mole_hit, state, stage, lives, score, timer
    );

    modport master (
        output sec_tick, btn_press, btn_code, mole_mask, snd_busy,
        input  snd_trig, snd_mode, mole_en, mole_hit, state, stage, lives, score, timer
    );

endinterface

// File: rtl/mole_game_ctrl_edge_sync.sv
// Two-flop synchroniser for an asynchronous level plus a one-cycle rising-edge pulse.
module mole_edge_sync (
    input  logic clk_1mhz,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);
    import mole_pkg::*;

    logic [2:0] r_sync;

    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[1:0], i_async};
    end

    // r_sync[1] is the first metastability-safe copy; r_sync[2] is its history
    assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: phase sequencing, score/lives/stage/timer keeping
// and the sound request handshake.
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int N_HOLES    = 8,
    parameter int N_STAGES   = 4,
    parameter int LIVES_INIT = 3,
    parameter int READY_SEC  = 3,
    parameter int STAGE_SEC  = 60,
    parameter int SCORE_W    = 10,
    localparam int STAGE_W   = clog2_min1(N_STAGES),
    localparam int LIVES_W   = clog2_min1(LIVES_INIT + 1)
) (
    input  logic             clk_1mhz,
    input  logic             rst_n,
    mole_game_ctrl_if.slave  bus
);

    logic w_press;

    mole_edge_sync u_btn_sync (
        .clk_1mhz (clk_1mhz),
        .rst_n    (rst_n),
        .i_async  (bus.btn_press),
        .o_rise   (w_press)
    );

    state_e              r_state;
    end_ph_e             r_end_ph;
    logic [STAGE_W-1:0]  r_stage;
    logic [LIVES_W-1:0]  r_lives;
    logic [SCORE_W-1:0]  r_score;
    logic [6:0]          r_timer;
    logic                r_snd_trig;
    snd_e                r_snd_mode;
    logic [N_HOLES-1:0]  r_mole_hit;

    logic                w_hole, w_hit, w_miss, w_pause, w_start, w_last_stage;
    logic [N_HOLES-1:0]  w_sel;
    logic [SCORE_W:0]    w_score_sum;
    logic [SCORE_W-1:0]  w_score_nxt;
    snd_e                w_end_snd;

    assign w_hole  = w_press && (bus.btn_code != 4'd0) && (int'(bus.btn_code) <= N_HOLES);
    assign w_sel   = w_hole ? (N_HOLES'(1) << (bus.btn_code - 4'd1)) : '0;
    assign w_hit   = |(w_sel & bus.mole_mask);
    assign w_miss  = w_hole && !w_hit;
    assign w_pause = w_press && (bus.btn_code == BTN_PAUSE);
    assign w_start = w_press && (bus.btn_code == BTN_START);

    assign w_last_stage = int'(r_stage) >= N_STAGES - 1;

    // One extra bit catches the carry so the score can clamp instead of wrapping
    assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(r_stage) + (SCORE_W+1)'(1);
    assign w_score_nxt = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

    always_comb begin
        w_end_snd = SND_GAME_CLR;
        if (r_state == ST_STG_CLR)   w_end_snd = SND_STG_CLR;
        else if (r_state == ST_OVER) w_end_snd = SND_OVER;
    end

    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_end_ph   <= END_WAIT_IDLE;
            r_stage    <= '0;
            r_lives    <= LIVES_W'(LIVES_INIT);
            r_score    <= '0;
            r_timer    <= '0;
            r_snd_trig <= 1'b0;
            r_snd_mode <= SND_NONE;
            r_mole_hit <= '0;
        end else begin
            r_snd_trig <= 1'b0;
            r_mole_hit <= '0;
            unique case (r_state)
                ST_IDLE: if (w_start) begin
                    r_state <= ST_COUNT;
                    r_timer <= 7'(READY_SEC);
                    if (r_stage == '0) begin
                        r_score <= '0;
                        r_lives <= LIVES_W'(LIVES_INIT);
                    end
                end
                ST_COUNT: if (bus.sec_tick) begin
                    if (!bus.snd_busy) r_snd_trig <= 1'b1;
                    if (r_timer > 7'd1) begin
                        r_timer <= r_timer - 7'd1;
                        if (!bus.snd_busy) r_snd_mode <= SND_BEEP;
                    end else begin
                        r_timer <= 7'(STAGE_SEC);
                        r_state <= ST_PLAY;
                        if (!bus.snd_busy) r_snd_mode <= SND_GO;
                    end
                end
                ST_PLAY: begin
                    if ((w_hit || w_miss) && !bus.snd_busy) begin
                        r_snd_trig <= 1'b1;
                        r_snd_mode <= w_hit ? SND_HIT : SND_MISS;
                    end
                    // Presses resolve before the tick, so a fatal miss beats an expiring timer
                    if (w_pause) begin
                        r_state <= ST_PAUSE;
                    end else if (w_miss && r_lives <= LIVES_W'(1)) begin
                        r_lives  <= '0;
                        r_timer  <= '0;
                        r_state  <= ST_OVER;
                        r_end_ph <= END_WAIT_IDLE;
                    end else begin
                        if (w_hit) begin
                            r_score    <= w_score_nxt;
                            r_mole_hit <= w_sel;
                        end
                        if (w_miss) r_lives <= r_lives - LIVES_W'(1);
                        if (bus.sec_tick && r_timer != 7'd0) begin
                            r_timer <= r_timer - 7'd1;
                            if (r_timer == 7'd1) begin
                                r_state  <= w_last_stage ? ST_GAME_CLR : ST_STG_CLR;
                                r_end_ph <= END_WAIT_IDLE;
                            end
                        end
                    end
                end
                ST_PAUSE: if (w_pause) r_state <= ST_PLAY;
                default: begin
                    unique case (r_end_ph)
                        END_WAIT_IDLE: if (!bus.snd_busy) begin
                            r_snd_trig <= 1'b1;
                            r_snd_mode <= w_end_snd;
                            r_end_ph   <= END_WAIT_BUSY;
                        end
                        END_WAIT_BUSY: if (bus.snd_busy) r_end_ph <= END_WAIT_DONE;
                        default: if (!bus.snd_busy) begin
                            r_state  <= ST_IDLE;
                            r_end_ph <= END_WAIT_IDLE;
                            r_stage  <= (r_state == ST_STG_CLR) ? r_stage + STAGE_W'(1) : '0;
                        end
                    endcase
                end
            endcase
        end
    end

    assign bus.snd_trig = r_snd_trig;
    assign bus.snd_mode = r_snd_mode;
    assign bus.mole_en  = (r_state == ST_PLAY);
    assign bus.mole_hit = r_mole_hit;
    assign bus.state    = r_state;
    assign bus.stage    = r_stage;
    assign bus.lives    = r_lives;
    assign bus.score    = r_score;
    assign bus.timer    = r_timer;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: directed game flows plus random play, checked against
// an action-level game model.
`timescale 1ns/1ps
module tb_mole_game_ctrl;
    import mole_pkg::*;

    localparam int NH = 8, NS = 2, LIV = 3, RDY = 3, STG = 60, SCW = 10;
    localparam int SW   = clog2_min1(NS);
    localparam int LW   = clog2_min1(LIV + 1);
    localparam int SMAX = (1 << SCW) - 1;

    logic clk_1mhz = 1'b0;
    logic rst_n;
    always #5 clk_1mhz = ~clk_1mhz;

    mole_game_ctrl_if #(.N_HOLES(NH), .STAGE_W(SW), .LIVES_W(LW), .SCORE_W(SCW)) bus();

    mole_game_ctrl #(
        .N_HOLES(NH), .N_STAGES(NS), .LIVES_INIT(LIV),
        .READY_SEC(RDY), .STAGE_SEC(STG), .SCORE_W(SCW)
    ) dut (
        .clk_1mhz (clk_1mhz),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Game model: 0 IDLE 1 COUNT 2 PLAY 3 PAUSE 4 STG_CLR 5 OVER 6 GAME_CLR
    int m_state, m_timer, m_score, m_lives, m_stage, m_mode;
    bit exp_trig;
    logic [NH-1:0] exp_hit;

    int end_trig_cnt = 0, end_base = 0;
    always @(negedge clk_1mhz)
        if (bus.snd_trig === 1'b1 && bus.snd_mode >= 3'd5) end_trig_cnt <= end_trig_cnt + 1;

    task automatic model_reset();
        m_state = 0; m_timer = 0; m_score = 0; m_lives = LIV; m_stage = 0; m_mode = 0;
    endtask

    task automatic model_step(input bit pr, input int code, input logic [NH-1:0] mask,
                              input bit tk, input bit bz);
        int snd = 0;
        bit done = 0;
        exp_trig = 0; exp_hit = '0;
        case (m_state)
            0: if (pr && code == 10) begin
                   if (m_stage == 0) begin m_score = 0; m_lives = LIV; end
                   m_state = 1; m_timer = RDY;
               end
            1: if (tk) begin
                   if (m_timer > 1) begin m_timer--; snd = 1; end
                   else begin m_timer = STG; m_state = 2; snd = 2; end
               end
            2: begin
                if (pr && code == 11) begin m_state = 3; done = 1; end
                else if (pr && code >= 1 && code <= NH) begin
                    if (mask[code-1]) begin
                        m_score = (m_score + m_stage + 1 > SMAX) ? SMAX : m_score + m_stage + 1;
                        exp_hit[code-1] = 1'b1; snd = 3;
                    end else begin
                        m_lives--; snd = 4;
                        if (m_lives == 0) begin m_state = 5; m_timer = 0; done = 1; end
                    end
                end
                if (!done && tk) begin
                    m_timer--;
                    if (m_timer == 0) m_state = (m_stage < NS - 1) ? 4 : 6;
                end
            end
            3: if (pr && code == 11) m_state = 2;
            default: ;
        endcase
        if (snd != 0 && !bz) begin exp_trig = 1; m_mode = snd; end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".state"}, bus.state, m_state);
        chk({tag, ".timer"}, bus.timer, m_timer);
        chk({tag, ".score"}, bus.score, m_score);
        chk({tag, ".lives"}, bus.lives, m_lives);
        chk({tag, ".stage"}, bus.stage, m_stage);
        chk({tag, ".mode"},  bus.snd_mode, m_mode);
        chk({tag, ".en"},    bus.mole_en, (m_state == 2));
    endtask

    // One action: optional button press and/or second tick landing on the same decision edge
    task automatic do_act(input bit pr, input int code, input logic [NH-1:0] mask,
                          input bit tk, input bit bz);
        @(posedge clk_1mhz); #1;
        bus.mole_mask = mask;
        bus.btn_code  = 4'(code);
        if (pr) begin
            bus.btn_press = 1'b1;
            @(posedge clk_1mhz); @(posedge clk_1mhz); #1;
        end
        bus.sec_tick = tk;
        bus.snd_busy = bz;
        model_step(pr, code, mask, tk, bz);
        @(posedge clk_1mhz); #1;
        bus.sec_tick = 1'b0; bus.snd_busy = 1'b0; bus.btn_press = 1'b0;
        @(negedge clk_1mhz);
        chk("act.trig", bus.snd_trig, exp_trig);
        chk("act.hit", bus.mole_hit, exp_hit);
        chk_regs("act");
        @(negedge clk_1mhz);
        chk("act.hit_clr", bus.mole_hit, 0);
        repeat (2) @(posedge clk_1mhz);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) do_act(0, 0, '0, 1, 0);
    endtask

    task automatic end_seq();
        int cyc = 0;
        int em;
        em = (m_state == 4) ? 5 : (m_state == 5) ? 6 : 7;
        while (end_trig_cnt == end_base && cyc < 20) begin @(negedge clk_1mhz); cyc++; end
        chk("end.trig_cnt", end_trig_cnt - end_base, 1);
        m_mode = em;
        chk("end.mode", bus.snd_mode, em);
        repeat (3) @(negedge clk_1mhz);
        chk("end.wait_busy", bus.state, m_state);
        @(posedge clk_1mhz); #1 bus.snd_busy = 1'b1;
        repeat (4) @(negedge clk_1mhz);
        chk("end.busy_hold", bus.state, m_state);
        @(posedge clk_1mhz); #1 bus.snd_busy = 1'b0;
        repeat (3) @(negedge clk_1mhz);
        m_stage = (m_state == 4) ? m_stage + 1 : 0;
        m_state = 0; m_timer = 0;
        chk_regs("end");
        chk("end.no_repeat", end_trig_cnt - end_base, 1);
        end_base = end_trig_cnt;
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            int code, r;
            logic [NH-1:0] mask;
            bit pr, tk, bz;
            mask = NH'($urandom);
            bz   = ($urandom_range(0, 9) == 0);
            pr = 0; tk = 0; code = 0;
            if (m_state >= 4) end_seq();
            else begin
                case (m_state)
                    0: begin pr = 1; tk = $urandom_range(0, 1);
                             code = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 10; end
                    1: begin pr = $urandom_range(0, 1); tk = 1; code = $urandom_range(0, 15); end
                    2: begin
                        r = $urandom_range(0, 19);
                        if (r < 8) tk = 1;
                        else begin
                            pr = 1;
                            tk = ($urandom_range(0, 3) == 0);
                            code = (r == 8) ? $urandom_range(0, 15) : $urandom_range(1, NH);
                            if (r > 8) mask[code-1] = 1'b1;
                        end
                    end
                    default: begin pr = $urandom_range(0, 1); tk = $urandom_range(0, 1);
                                   code = ($urandom_range(0, 2) == 0) ? 11 : $urandom_range(0, 15); end
                endcase
                do_act(pr, code, mask, tk, bz);
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"}, bus.state, 0);
        chk({tag, ".stage"}, bus.stage, 0);
        chk({tag, ".lives"}, bus.lives, LIV);
        chk({tag, ".score"}, bus.score, 0);
        chk({tag, ".timer"}, bus.timer, 0);
        chk({tag, ".trig"},  bus.snd_trig, 0);
        chk({tag, ".mode"},  bus.snd_mode, 0);
        chk({tag, ".en"},    bus.mole_en, 0);
        chk({tag, ".hit"},   bus.mole_hit, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sec_tick = 0; bus.btn_press = 0; bus.btn_code = 0; bus.mole_mask = '0; bus.snd_busy = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_1mhz);
        chk_reset_vals("rst");
        @(posedge clk_1mhz); #1 rst_n = 1'b1;

        // Countdown into play
        do_act(1, 10, '0, 0, 0);
        chk("start.timer", bus.timer, RDY);
        tick_n(3);
        chk("cnt.state", bus.state, 2);
        chk("cnt.timer", bus.timer, STG);
        chk("cnt.en", bus.mole_en, 1);

        // Pause freezes the timer
        tick_n(30);
        do_act(1, 11, '0, 0, 0);
        tick_n(5);
        chk("pause.timer", bus.timer, 30);
        chk("pause.en", bus.mole_en, 0);
        do_act(1, 11, '0, 0, 0);
        tick_n(1);
        chk("resume.timer", bus.timer, 29);

        // Expire stage 0
        tick_n(29);
        chk("stg0.state", bus.state, 4);
        end_seq();
        chk("stg0.next", bus.stage, 1);

        // Stage 1 hit, miss, hit with busy sound
        do_act(1, 10, '0, 0, 0);
        tick_n(3);
        do_act(1, 3, 8'h04, 0, 0);
        chk("hit.score", bus.score, 2);
        do_act(1, 5, 8'h04, 0, 0);
        chk("miss.lives", bus.lives, 2);
        do_act(1, 3, 8'h04, 0, 1);
        chk("busy.score", bus.score, 4);

        // Fatal miss on the expiring tick
        do_act(1, 6, 8'h04, 0, 0);
        while (m_timer > 1) do_act(0, 0, '0, 1, 0);
        do_act(1, 5, 8'h04, 1, 0);
        chk("over.state", bus.state, 5);
        end_seq();
        chk("over.stage", bus.stage, 0);

        // Full game clear
        do_act(1, 10, '0, 0, 0);
        tick_n(RDY + STG);
        end_seq();
        do_act(1, 10, '0, 0, 0);
        tick_n(RDY + STG);
        chk("gclr.state", bus.state, 6);
        end_seq();

        rand_run(800);

        // Asynchronous reset mid-cycle
        @(negedge clk_1mhz); #2 rst_n = 1'b0; #1;
        chk_reset_vals("mid_rst");
        model_reset();
        @(posedge clk_1mhz); #1 rst_n = 1'b1;

        // Score saturation
        do_act(1, 10, '0, 0, 0);
        tick_n(RDY);
        for (int i = 0; i < SMAX + 7; i++) do_act(1, 1, 8'h01, 0, 0);
        chk("sat.score", bus.score, SMAX);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
